// File: rtl/track_sequencer.sv
// Speech-track sequencer: turns a 0..100 percentage into a short list of flash
// tracks and streams them to the AC97 one byte per ready strobe.
module track_sequencer #(
  parameter int unsigned TRACK_LENGTH = 48000,
  parameter int unsigned BASE_ADDR    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [6:0]  value,
  input  logic        ready,
  input  logic        busy,
  input  logic [15:0] frdata,
  output logic [22:0] raddr,
  output logic        doread,
  output logic [7:0]  sample,
  output logic        playing,
  output logic        done,
  output logic        error
);

  localparam logic [22:0] TrackLen  = 23'(TRACK_LENGTH);
  localparam logic [22:0] BaseAddr  = 23'(BASE_ADDR);
  localparam logic [15:0] LastOff   = 16'(TRACK_LENGTH - 1);
  localparam logic [4:0]  TrkHundred = 5'd23;
  localparam logic [4:0]  TrkTeen    = 5'd24;
  localparam logic [4:0]  TrkPercent = 5'd25;
  localparam logic [4:0]  TrkUsed    = 5'd26;

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      value_q;
  logic [3:0][4:0] queue_q, build_queue;
  logic [2:0]      len_q, build_len;
  logic [1:0]      idx_q;
  logic [15:0]     offset_q;
  logic [22:0]     raddr_q;
  logic [7:0]      sample_q;
  logic            error_q;
  logic            advance, last_word, more_tracks, start_ok, aborting;
  logic [6:0]      tens, ones;

  function automatic logic [22:0] track_addr(input logic [4:0] trk);
    return BaseAddr + 23'(trk) * TrackLen;
  endfunction

  assign advance     = ready && !busy;
  assign last_word   = offset_q >= LastOff;
  assign more_tracks = ({1'b0, idx_q} + 3'd1) < len_q;
  assign start_ok    = start && (value <= 7'd100);
  assign aborting    = abort && (state_q != StIdle);

  // Word list for the captured value; ONE..NINE are indices 0..8, TWENTY is 15.
  always_comb begin
    tens        = value_q / 7'd10;
    ones        = value_q % 7'd10;
    build_queue = '0;
    build_len   = 3'd0;
    if (value_q == 7'd0) begin
      build_queue[0] = TrkPercent;
      build_queue[1] = TrkUsed;
      build_len      = 3'd2;
    end else if (value_q <= 7'd15) begin
      build_queue[0] = 5'(value_q - 7'd1);
      build_queue[1] = TrkPercent;
      build_queue[2] = TrkUsed;
      build_len      = 3'd3;
    end else if (value_q <= 7'd19) begin
      build_queue[0] = 5'(value_q - 7'd11);
      build_queue[1] = TrkTeen;
      build_queue[2] = TrkPercent;
      build_queue[3] = TrkUsed;
      build_len      = 3'd4;
    end else if (value_q == 7'd100) begin
      build_queue[0] = TrkHundred;
      build_queue[1] = TrkPercent;
      build_queue[2] = TrkUsed;
      build_len      = 3'd3;
    end else if (ones == 7'd0) begin
      build_queue[0] = 5'(tens + 7'd13);
      build_queue[1] = TrkPercent;
      build_queue[2] = TrkUsed;
      build_len      = 3'd3;
    end else begin
      build_queue[0] = 5'(tens + 7'd13);
      build_queue[1] = 5'(ones - 7'd1);
      build_queue[2] = TrkPercent;
      build_queue[3] = TrkUsed;
      build_len      = 3'd4;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_ok) state_d = StLoad;
      StLoad: state_d = StPlay;
      StPlay: if (advance && last_word && !more_tracks) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (aborting) state_d = StIdle;
  end

  assign playing = (state_q == StPlay);
  assign doread  = (state_q == StPlay);
  // An abort arriving in DONE suppresses the completion pulse.
  assign done    = (state_q == StDone) && !abort;
  assign raddr   = raddr_q;
  assign sample  = sample_q;
  assign error   = error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q  <= '0;
      queue_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      offset_q <= '0;
      raddr_q  <= '0;
      sample_q <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= (state_q == StIdle) && start && (value > 7'd100);
      if (aborting) begin
        raddr_q  <= '0;
        sample_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: if (start_ok) value_q <= value;
          StLoad: begin
            queue_q  <= build_queue;
            len_q    <= build_len;
            idx_q    <= '0;
            offset_q <= '0;
            raddr_q  <= track_addr(build_queue[0]);
          end
          StPlay: begin
            if (advance) begin
              sample_q <= frdata[15:8];
              if (!last_word) begin
                raddr_q  <= raddr_q + 23'd1;
                offset_q <= offset_q + 16'd1;
              end else if (more_tracks) begin
                idx_q    <= idx_q + 2'd1;
                raddr_q  <= track_addr(queue_q[idx_q + 2'd1]);
                offset_q <= '0;
              end
            end
          end
          StDone: begin
            sample_q <= '0;
            raddr_q  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_track_sequencer.sv
// Randomised bench for track_sequencer against a word-list reference model.
module tb_track_sequencer;
  localparam int TL = 4;
  localparam int BA = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  value = '0;
  logic        ready = 1'b0;
  logic        busy = 1'b0;
  logic [15:0] frdata = '0;
  logic [22:0] raddr;
  logic        doread, playing, done, error;
  logic [7:0]  sample;

  int checks = 0;
  int errors = 0;
  int exp_trk[$];
  logic [7:0] exp_sample = '0;

  track_sequencer #(.TRACK_LENGTH(TL), .BASE_ADDR(BA)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .value(value),
    .ready(ready), .busy(busy), .frdata(frdata), .raddr(raddr), .doread(doread),
    .sample(sample), .playing(playing), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Spoken form of a percentage as track indices.
  task automatic model_tracks(input int v);
    exp_trk.delete();
    if (v == 0) begin
    end else if (v <= 15) exp_trk.push_back(v - 1);
    else if (v <= 19) begin
      exp_trk.push_back(v - 11);
      exp_trk.push_back(24);
    end else if (v == 100) exp_trk.push_back(23);
    else begin
      exp_trk.push_back(15 + v / 10 - 2);
      if (v % 10 != 0) exp_trk.push_back(v % 10 - 1);
    end
    exp_trk.push_back(25);
    exp_trk.push_back(26);
  endtask

  task automatic do_start(input int v);
    value = 7'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input int addr);
    frdata = 16'($urandom);
    ready  = 1'b1;
    busy   = 1'b0;
    checks++;
    if (raddr !== 23'(addr)) begin
      errors++;
      $display("FAIL raddr before strobe: got %0d want %0d", raddr, addr);
    end
    tick();
    ready = 1'b0;
    exp_sample = frdata[15:8];
    checks++;
    if (sample !== exp_sample) begin
      errors++;
      $display("FAIL sample after strobe: got %0h want %0h", sample, exp_sample);
    end
  endtask

  // mode 0: clean; 1: random stalls and stray starts; 2: 3 busy strobes after 2nd sample
  task automatic play_sequence(input int v, input int mode);
    int n_words, k;
    model_tracks(v);
    n_words = exp_trk.size() * TL;
    do_start(v);
    tick();
    checks++;
    if (playing !== 1'b1 || doread !== 1'b1) begin
      errors++;
      $display("FAIL playing after load: got %b/%b want 1/1", playing, doread);
    end
    k = 0;
    foreach (exp_trk[t]) begin
      for (int off = 0; off < TL; off++) begin
        int addr, stalls;
        addr = BA + exp_trk[t] * TL + off;
        stalls = (mode == 1) ? $urandom_range(0, 2) : ((mode == 2 && k == 2) ? 3 : 0);
        for (int s = 0; s < stalls; s++) begin
          ready = (mode == 2) ? 1'b1 : 1'($urandom);
          busy  = 1'b1;
          start = (mode == 1) ? 1'($urandom) : 1'b0;
          value = 7'($urandom);
          frdata = 16'($urandom);
          tick();
          ready = 1'b0;
          busy  = 1'b0;
          start = 1'b0;
          checks++;
          if (raddr !== 23'(addr) || sample !== exp_sample) begin
            errors++;
            $display("FAIL stall hold: raddr %0d sample %0h want %0d %0h",
                     raddr, sample, addr, exp_sample);
          end
        end
        strobe(addr);
        k++;
        checks++;
        if (done !== (k == n_words)) begin
          errors++;
          $display("FAIL done at strobe %0d of %0d: got %b", k, n_words, done);
        end
      end
    end
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL playing in done: got %b want 0", playing);
    end
    tick();
    exp_sample = '0;
    checks++;
    if (done !== 1'b0 || raddr !== '0 || sample !== '0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL after done: done %b raddr %0d sample %0h playing %b want 0 0 0 0",
               done, raddr, sample, playing);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({raddr, doread, sample, playing, done, error} !== '0) begin
      errors++;
      $display("FAIL reset outputs: raddr %0d doread %b sample %0h playing %b done %b error %b",
               raddr, doread, sample, playing, done, error);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    play_sequence(42, 0);
    play_sequence(0, 0);
    play_sequence(17, 0);
    play_sequence(100, 0);
  endtask

  task automatic test_busy_hold;
    play_sequence(42, 2);
  endtask

  task automatic test_error;
    for (int i = 0; i < 3; i++) begin
      do_start($urandom_range(101, 127));
      checks++;
      if (error !== 1'b1 || playing !== 1'b0 || raddr !== '0) begin
        errors++;
        $display("FAIL reject: error %b playing %b raddr %0d want 1 0 0", error, playing, raddr);
      end
      tick();
      checks++;
      if (error !== 1'b0 || playing !== 1'b0) begin
        errors++;
        $display("FAIL reject pulse width: error %b playing %b want 0 0", error, playing);
      end
    end
  endtask

  task automatic test_abort;
    do_start(100);
    tick();
    for (int i = 0; i < 5; i++) strobe(BA + 23 * TL + (i % TL) + ((i / TL) * (2 * TL)));
    ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ready = 1'b0;
    exp_sample = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (playing !== 1'b0 || done !== 1'b0 || raddr !== '0 || sample !== '0) begin
        errors++;
        $display("FAIL abort: playing %b done %b raddr %0d sample %0h want 0 0 0 0",
                 playing, done, raddr, sample);
      end
      tick();
    end
    play_sequence(5, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) play_sequence($urandom_range(0, 100), 1);
  endtask

  task automatic test_reset_mid_play;
    do_start(42);
    tick();
    strobe(69);
    strobe(70);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (raddr !== '0 || playing !== 1'b0 || done !== 1'b0 || sample !== '0) begin
      errors++;
      $display("FAIL async reset: raddr %0d playing %b done %b sample %0h", raddr, playing,
               done, sample);
    end
    tick();
    reset = 1'b0;
    exp_sample = '0;
    tick();
    play_sequence($urandom_range(1, 99), 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_hold();
    test_error();
    test_abort();
    test_random();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
